dual_clock_fifo_fwft_reader: RTL and testbench

- Read-side consumer for the dual-clock FIFO. Lives in the read clock domain.
- Drives the FIFO's pop/empty/data port, which has one cycle of read latency. Presents a first-word-fall-through valid/ready stream to downstream logic.
- Prefetches into a small register buffer so back-to-back transfers sustain one word per clock.
- Has no combinational path from i_ready to o_fifo_rd_inc.

---
 rtl/dual_clock_fifo_fwft_reader_pkg.sv | 11 +
 rtl/dual_clock_fifo_fwft_reader_if.sv | 38 +++
 rtl/dual_clock_fifo_fwft_reader_fwft_reg_buffer.sv | 61 ++++++
 rtl/dual_clock_fifo_fwft_reader.sv | 69 ++++++
 tb/tb_dual_clock_fifo_fwft_reader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_clock_fifo_fwft_reader_pkg.sv
// Shared constants and helpers for the dual-clock FIFO read-side blocks.
package dual_clock_fifo_fwft_reader_pkg;

    // Cycles from a pop request to valid FIFO read data; sets the landing pipe depth.
    localparam int unsigned L_FIFO_RD_LATENCY = 1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dual_clock_fifo_fwft_reader_if.sv
// FIFO pop port plus first-word-fall-through stream between reader and its neighbours.
interface dual_clock_fifo_fwft_reader_if
    import dual_clock_fifo_fwft_reader_pkg::*;
#(
    parameter int unsigned P_DATA_MSB  = 7,
    parameter int unsigned P_BUF_DEPTH = 3
);
    localparam int unsigned L_CNT_W = clog2_min1(P_BUF_DEPTH + 1);

    logic                 o_fifo_rd_inc;
    logic                 i_fifo_empty;
    logic [P_DATA_MSB:0]  i_fifo_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [P_DATA_MSB:0]  o_data;
    logic [L_CNT_W-1:0]   o_count;

    modport master (
        output o_fifo_rd_inc,
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_count
    );

    modport slave (
        input  o_fifo_rd_inc,
        output i_fifo_empty,
        output i_fifo_data,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_count
    );

endinterface

// File: rtl/dual_clock_fifo_fwft_reader_fwft_reg_buffer.sv
// Prefetch register ring: P_BUF_DEPTH entries with write/read index and occupancy count.
module dual_clock_fifo_fwft_reader_fwft_reg_buffer
    import dual_clock_fifo_fwft_reader_pkg::*;
#(
    parameter int unsigned P_DATA_MSB  = 7,
    parameter int unsigned P_BUF_DEPTH = 3,
    localparam int unsigned L_CNT_W    = clog2_min1(P_BUF_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [P_DATA_MSB:0] wr_data_i,
    input  logic                rd_en_i,
    output logic [P_DATA_MSB:0] rd_data_o,
    output logic [L_CNT_W-1:0]  count_o
);
    localparam int unsigned L_IDX_W = clog2_min1(P_BUF_DEPTH);

    typedef logic [L_IDX_W-1:0] idx_t;
    typedef logic [L_CNT_W-1:0] cnt_t;

    localparam idx_t L_LAST = idx_t'(P_BUF_DEPTH - 1);

    logic [P_DATA_MSB:0] mem_q [P_BUF_DEPTH];
    idx_t                wr_idx_q;
    idx_t                rd_idx_q;
    cnt_t                count_q;

    // Explicit wrap so non-power-of-two depths work.
    function automatic idx_t idx_next(input idx_t idx);
        return (idx == L_LAST) ? '0 : idx + idx_t'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(P_BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_q] <= wr_data_i;
                wr_idx_q        <= idx_next(wr_idx_q);
            end
            if (rd_en_i) begin
                rd_idx_q <= idx_next(rd_idx_q);
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_idx_q];
    assign count_o   = count_q;

endmodule

// File: rtl/dual_clock_fifo_fwft_reader.sv
// Read-domain FIFO consumer: credit-based pop issue, landing pipe and FWFT prefetch buffer.
module dual_clock_fifo_fwft_reader
    import dual_clock_fifo_fwft_reader_pkg::*;
#(
    parameter int unsigned P_DATA_MSB  = 7,
    parameter int unsigned P_BUF_DEPTH = 3
) (
    input logic                        i_clk,
    input logic                        i_rst,
    dual_clock_fifo_fwft_reader_if.master bus
);
    localparam int unsigned L_CNT_W = clog2_min1(P_BUF_DEPTH + 1);

    logic [L_FIFO_RD_LATENCY-1:0] r_inflight;
    logic [L_FIFO_RD_LATENCY-1:0] inflight_d;
    logic                         rd_inc;
    logic                         land;
    logic                         xfer;
    logic                         valid;
    logic [L_CNT_W-1:0]           count;
    logic [P_DATA_MSB:0]          data;
    int unsigned                  occupancy;

    // Buffered plus in-flight words; only registered state feeds the pop decision.
    always_comb begin
        occupancy = 32'(count);
        for (int i = 0; i < int'(L_FIFO_RD_LATENCY); i++) begin
            occupancy = occupancy + 32'(r_inflight[i]);
        end
    end

    assign rd_inc = !bus.i_fifo_empty && (occupancy < P_BUF_DEPTH);

    always_comb begin
        inflight_d    = r_inflight << 1;
        inflight_d[0] = rd_inc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= inflight_d;
        end
    end

    assign land  = r_inflight[L_FIFO_RD_LATENCY-1];
    assign valid = (count != '0);
    assign xfer  = valid && bus.i_ready;

    dual_clock_fifo_fwft_reader_fwft_reg_buffer #(
        .P_DATA_MSB  (P_DATA_MSB),
        .P_BUF_DEPTH (P_BUF_DEPTH)
    ) u_buf (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wr_en_i   (land),
        .wr_data_i (bus.i_fifo_data),
        .rd_en_i   (xfer),
        .rd_data_o (data),
        .count_o   (count)
    );

    assign bus.o_fifo_rd_inc = rd_inc;
    assign bus.o_valid       = valid;
    assign bus.o_data        = data;
    assign bus.o_count       = count;

endmodule

// File: tb/tb_dual_clock_fifo_fwft_reader.sv
// Self-checking bench: FIFO model, scoreboard and stream-rule monitor for depth 3 and 2.
module tb_dual_clock_fifo_fwft_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_clock_fifo_fwft_reader_if #(.P_DATA_MSB(7), .P_BUF_DEPTH(3)) bus3 ();
    dual_clock_fifo_fwft_reader_if #(.P_DATA_MSB(7), .P_BUF_DEPTH(2)) bus2 ();

    dual_clock_fifo_fwft_reader #(.P_DATA_MSB(7), .P_BUF_DEPTH(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3)
    );

    dual_clock_fifo_fwft_reader #(.P_DATA_MSB(7), .P_BUF_DEPTH(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [7:0] q3[$];
    logic [7:0] q2[$];
    logic [7:0] exp3[$];
    logic [7:0] exp2[$];
    int         pops3, pops2;
    logic       infl3, infl2;

    logic       s_rd3, s_val3, s_x3;
    logic [7:0] s_data3;
    logic [1:0] s_cnt3;
    logic       s_rd2, s_val2, s_x2;
    logic [7:0] s_data2;
    logic [1:0] s_cnt2;

    // Invariants and stream rules, checked every cycle outside reset.
    logic       pv3, pr3, pv2, pr2;
    logic [7:0] pd3, pd2;
    always @(negedge clk) begin
        if (rst) begin
            pv3 <= 1'b0;
            pv2 <= 1'b0;
        end else begin
            if (bus3.o_fifo_rd_inc && bus3.i_fifo_empty) begin
                viol <= viol + 1;
                $display("FAIL inv_pop_empty3: rd_inc=1 while empty=1");
            end
            if (bus2.o_fifo_rd_inc && bus2.i_fifo_empty) begin
                viol <= viol + 1;
                $display("FAIL inv_pop_empty2: rd_inc=1 while empty=1");
            end
            if (32'(bus3.o_count) + 32'(infl3) > 32'd3) begin
                viol <= viol + 1;
                $display("FAIL inv_occ3: count=%0d inflight=%0d limit 3", bus3.o_count, infl3);
            end
            if (32'(bus2.o_count) + 32'(infl2) > 32'd2) begin
                viol <= viol + 1;
                $display("FAIL inv_occ2: count=%0d inflight=%0d limit 2", bus2.o_count, infl2);
            end
            if (pv3 && !pr3 && (!bus3.o_valid || bus3.o_data !== pd3)) begin
                viol <= viol + 1;
                $display("FAIL stream3: valid=%0d data=%0h held %0h", bus3.o_valid, bus3.o_data, pd3);
            end
            if (pv2 && !pr2 && (!bus2.o_valid || bus2.o_data !== pd2)) begin
                viol <= viol + 1;
                $display("FAIL stream2: valid=%0d data=%0h held %0h", bus2.o_valid, bus2.o_data, pd2);
            end
            pv3 <= bus3.o_valid;
            pr3 <= bus3.i_ready;
            pd3 <= bus3.o_data;
            pv2 <= bus2.o_valid;
            pr2 <= bus2.i_ready;
            pd2 <= bus2.o_data;
        end
    end

    task automatic push3(input logic [7:0] w);
        q3.push_back(w);
        exp3.push_back(w);
        bus3.i_fifo_empty = 1'b0;
    endtask

    task automatic push2(input logic [7:0] w);
        q2.push_back(w);
        exp2.push_back(w);
        bus2.i_fifo_empty = 1'b0;
    endtask

    // One read-clock cycle: sample outputs mid-cycle, then apply the FIFO's response to the edge.
    task automatic tick();
        @(negedge clk);
        s_rd3   = bus3.o_fifo_rd_inc;
        s_val3  = bus3.o_valid;
        s_data3 = bus3.o_data;
        s_cnt3  = bus3.o_count;
        s_x3    = bus3.o_valid && bus3.i_ready;
        s_rd2   = bus2.o_fifo_rd_inc;
        s_val2  = bus2.o_valid;
        s_data2 = bus2.o_data;
        s_cnt2  = bus2.o_count;
        s_x2    = bus2.o_valid && bus2.i_ready;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (s_rd3) begin
                pops3++;
                if (q3.size() != 0) bus3.i_fifo_data = q3.pop_front();
            end
            infl3 = s_rd3;
            bus3.i_fifo_empty = (q3.size() == 0);
            if (s_rd2) begin
                pops2++;
                if (q2.size() != 0) bus2.i_fifo_data = q2.pop_front();
            end
            infl2 = s_rd2;
            bus2.i_fifo_empty = (q2.size() == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q3.delete();
        q2.delete();
        exp3.delete();
        exp2.delete();
        bus3.i_fifo_empty = 1'b1;
        bus3.i_fifo_data  = '0;
        bus3.i_ready      = 1'b0;
        bus2.i_fifo_empty = 1'b1;
        bus2.i_fifo_data  = '0;
        bus2.i_ready      = 1'b0;
        infl3 = 1'b0;
        infl2 = 1'b0;
        pops3 = 0;
        pops2 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        int v0;
        v0 = viol;
        do_reset();
        tick();
        checks++; if (s_rd3 !== 1'b0) begin errors++; $display("FAIL reset_rd_inc: got %0d want 0", s_rd3); end
        checks++; if (s_val3 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", s_val3); end
        checks++; if (s_cnt3 !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", s_cnt3); end
        checks++; if (s_data3 !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 0", s_data3); end
        checks++; if (s_val2 !== 1'b0 || s_rd2 !== 1'b0) begin
            errors++; $display("FAIL reset_dut2: valid=%0d rd_inc=%0d want 0 0", s_val2, s_rd2);
        end
        checks++; if (viol !== v0) begin errors++; $display("FAIL reset_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_single_word();
        int v0;
        v0 = viol;
        do_reset();
        repeat (3) tick();
        push3(8'hA5);
        tick();
        checks++; if (s_rd3 !== 1'b1) begin errors++; $display("FAIL single_pop_c0: got %0d want 1", s_rd3); end
        checks++; if (s_val3 !== 1'b0) begin errors++; $display("FAIL single_valid_c0: got %0d want 0", s_val3); end
        tick();
        checks++; if (s_rd3 !== 1'b0) begin errors++; $display("FAIL single_pop_c1: got %0d want 0", s_rd3); end
        checks++; if (s_val3 !== 1'b0) begin errors++; $display("FAIL single_valid_c1: got %0d want 0", s_val3); end
        tick();
        checks++; if (s_val3 !== 1'b1) begin errors++; $display("FAIL single_valid_c2: got %0d want 1", s_val3); end
        checks++; if (s_data3 !== 8'hA5) begin errors++; $display("FAIL single_data_c2: got %0h want a5", s_data3); end
        checks++; if (s_cnt3 !== 2'd1) begin errors++; $display("FAIL single_count_c2: got %0d want 1", s_cnt3); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (s_rd3 !== 1'b0 || s_val3 !== 1'b1 || s_data3 !== 8'hA5) begin
                errors++;
                $display("FAIL single_hold: rd_inc=%0d valid=%0d data=%0h want 0 1 a5", s_rd3, s_val3, s_data3);
            end
        end
        checks++; if (pops3 !== 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pops3); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL single_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_streaming();
        int v0, first, last, n;
        logic [7:0] w;
        v0 = viol; first = -1; last = -1; n = 0;
        do_reset();
        bus3.i_ready = 1'b1;
        for (int i = 0; i < 16; i++) push3(8'(i));
        for (int k = 0; k < 22; k++) begin
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL stream_data: got %0h want %0h", s_data3, w); end
                if (first < 0) first = k;
                last = k;
                n++;
            end
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL stream_first: got %0d want 2", first); end
        checks++; if (last !== 17) begin errors++; $display("FAIL stream_last: got %0d want 17", last); end
        checks++; if (n !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", n); end
        checks++; if (pops3 !== 16) begin errors++; $display("FAIL stream_pops: got %0d want 16", pops3); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL stream_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_backpressure();
        int v0, n;
        logic [7:0] w;
        v0 = viol; n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) push3(8'(i));
        repeat (10) tick();
        checks++; if (pops3 !== 3) begin errors++; $display("FAIL bp_pops: got %0d want 3", pops3); end
        checks++; if (s_cnt3 !== 2'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", s_cnt3); end
        checks++; if (s_val3 !== 1'b1 || s_data3 !== 8'h00) begin
            errors++; $display("FAIL bp_head: valid=%0d data=%0h want 1 00", s_val3, s_data3);
        end
        bus3.i_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL bp_data: got %0h want %0h", s_data3, w); end
                n++;
            end
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL bp_xfers: got %0d want 8", n); end
        checks++; if (pops3 !== 8) begin errors++; $display("FAIL bp_total_pops: got %0d want 8", pops3); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL bp_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_simultaneous();
        int v0, n;
        logic [7:0] w;
        v0 = viol; n = 0;
        do_reset();
        push3(8'h30);
        push3(8'h31);
        repeat (4) tick();
        checks++; if (s_cnt3 !== 2'd2) begin errors++; $display("FAIL simul_start_count: got %0d want 2", s_cnt3); end
        for (int i = 2; i < 12; i++) push3(8'(8'h30 + i));
        for (int k = 0; k < 16; k++) begin
            bus3.i_ready = (k % 2 == 0);
            tick();
            checks++;
            if (s_cnt3 < 2'd1 || s_cnt3 > 2'd3) begin
                errors++; $display("FAIL simul_count_range: got %0d want 1..3", s_cnt3);
            end
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL simul_data: got %0h want %0h", s_data3, w); end
                n++;
            end
        end
        bus3.i_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL simul_drain: got %0h want %0h", s_data3, w); end
                n++;
            end
        end
        checks++; if (n !== 12) begin errors++; $display("FAIL simul_xfers: got %0d want 12", n); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL simul_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        logic [7:0] w;
        v0 = viol;
        do_reset();
        bus3.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) push3(8'(8'h50 + i));
        for (int k = 0; k < 5; k++) begin
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL rmid_data: got %0h want %0h", s_data3, w); end
            end
        end
        checks++; if (infl3 !== 1'b1 || s_val3 !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: inflight=%0d valid=%0d want 1 1", infl3, s_val3);
        end
        #2;
        rst = 1'b1;
        q3.delete();
        exp3.delete();
        bus3.i_fifo_empty = 1'b1;
        infl3 = 1'b0;
        #1;
        checks++; if (bus3.o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0d want 0", bus3.o_valid); end
        checks++; if (bus3.o_count !== 2'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", bus3.o_count); end
        checks++; if (bus3.o_data !== 8'h00) begin errors++; $display("FAIL rmid_data0: got %0h want 0", bus3.o_data); end
        checks++; if (bus3.o_fifo_rd_inc !== 1'b0) begin errors++; $display("FAIL rmid_rd_inc: got %0d want 0", bus3.o_fifo_rd_inc); end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (s_val3 !== 1'b0 || s_rd3 !== 1'b0) begin
                errors++; $display("FAIL rmid_after: valid=%0d rd_inc=%0d want 0 0", s_val3, s_rd3);
            end
        end
        checks++; if (viol !== v0) begin errors++; $display("FAIL rmid_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_random();
        int v0, pushed, n;
        logic [7:0] w;
        v0 = viol; pushed = 0; n = 0;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                push3(8'($urandom));
                pushed++;
            end
            bus3.i_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL rand_data: got %0h want %0h", s_data3, w); end
                n++;
            end
        end
        bus3.i_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_x3) begin
                w = (exp3.size() != 0) ? exp3.pop_front() : 'x;
                checks++; if (s_data3 !== w) begin errors++; $display("FAIL rand_drain: got %0h want %0h", s_data3, w); end
                n++;
            end
        end
        checks++; if (n !== pushed) begin errors++; $display("FAIL rand_xfers: got %0d want %0d", n, pushed); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL rand_invariants: got %0d want %0d", viol, v0); end
    endtask

    task automatic test_depth2();
        int v0, first, prev, maxgap, n;
        logic [7:0] w;
        v0 = viol; first = -1; prev = -1; maxgap = 0; n = 0;
        do_reset();
        bus2.i_ready = 1'b1;
        for (int i = 0; i < 12; i++) push2(8'(8'h70 + i));
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_x2) begin
                w = (exp2.size() != 0) ? exp2.pop_front() : 'x;
                checks++; if (s_data2 !== w) begin errors++; $display("FAIL d2_data: got %0h want %0h", s_data2, w); end
                if (first < 0) first = k;
                if (prev >= 0 && k - prev > maxgap) maxgap = k - prev;
                prev = k;
                n++;
            end
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL d2_first: got %0d want 2", first); end
        checks++; if (maxgap !== 2) begin errors++; $display("FAIL d2_maxgap: got %0d want 2", maxgap); end
        checks++; if (n !== 12) begin errors++; $display("FAIL d2_xfers: got %0d want 12", n); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL d2_invariants: got %0d want %0d", viol, v0); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_depth2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
